// File: rtl/sram_controller.sv
// Clocked initiator for an asynchronous SRAM: turns a single-cycle req/ack handshake
// into a setup / strobe / hold access with registered strobes and read sampling.
module sram_controller #(
  parameter int unsigned depth  = 16,
  parameter int unsigned width  = 8,
  parameter int          cycles = 2
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [depth-1:0] i_addr,
  input  logic [width-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_ack,
  output logic [width-1:0] o_rdata,
  output logic [depth-1:0] o_sram_addr,
  output logic             o_sram_enable_x,
  output logic             o_sram_write_x,
  output logic [width-1:0] o_sram_wdata,
  input  logic [width-1:0] i_sram_rdata
);

  localparam int unsigned ACC_CYC = (cycles < 1) ? 32'd1 : 32'(cycles);
  localparam int unsigned CNT_W   = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [depth-1:0]   addr_q, addr_d;
  logic [width-1:0]   wdata_q, wdata_d;
  logic [width-1:0]   rdata_q, rdata_d;
  logic               en_x_q, en_x_d;
  logic               wr_x_q, wr_x_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;

  // Next-state and next-output logic; strobes default high so only ACCESS can pull them low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    en_x_d  = 1'b1;
    wr_x_d  = 1'b1;
    busy_d  = busy_q;
    ack_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        en_x_d  = 1'b0;
        wr_x_d  = ~we_q;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = ST_HOLD;
          if (!we_q) begin
            rdata_d = i_sram_rdata;
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          en_x_d = 1'b0;
          wr_x_d = ~we_q;
        end
      end
      ST_HOLD: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drives both strobes high immediately.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      en_x_q  <= 1'b1;
      wr_x_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      en_x_q  <= en_x_d;
      wr_x_q  <= wr_x_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_ack           = ack_q;
  assign o_rdata         = rdata_q;
  assign o_sram_addr     = addr_q;
  assign o_sram_wdata    = wdata_q;
  assign o_sram_enable_x = en_x_q;
  assign o_sram_write_x  = wr_x_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances (cycles=2,0,1) each driving a behavioural SRAM,
// with a scoreboard of expected completions checked on every o_ack.
module tb_sram_controller;

  localparam int unsigned NI = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_x = 1'b1;

  logic          req     [NI];
  logic          we      [NI];
  logic [AW-1:0] addr    [NI];
  logic [DW-1:0] wdata   [NI];
  logic          busy    [NI];
  logic          ack     [NI];
  logic [DW-1:0] rdata   [NI];
  logic [AW-1:0] s_addr  [NI];
  logic          en_x    [NI];
  logic          wr_x    [NI];
  logic [DW-1:0] s_wdata [NI];
  logic [DW-1:0] s_rdata [NI];

  always #5 clk = ~clk;

  typedef struct {
    int            inst;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk;
  } sb_t;

  sb_t          sb_q[$];
  logic [DW-1:0] ref_mem [int];
  int  n_checks = 0;
  int  n_err    = 0;
  int  ack_cnt    [NI] = '{default: 0};
  int  strobe_cnt [NI] = '{default: 0};
  logic prev_en   [NI] = '{default: 1'b1};
  time last_acc;

  logic [AW-1:0] b2b_addr [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
  logic [DW-1:0] b2b_data [4] = '{8'h01, 8'h02, 8'h00, 8'h00};
  bit            b2b_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] mem [0:65535];

    sram_controller #(
      .depth (AW),
      .width (DW),
      .cycles((g == 0) ? 2 : g - 1)
    ) u_dut (
      .clk            (clk),
      .rst_x          (rst_x),
      .i_req          (req[g]),
      .i_we           (we[g]),
      .i_addr         (addr[g]),
      .i_wdata        (wdata[g]),
      .o_busy         (busy[g]),
      .o_ack          (ack[g]),
      .o_rdata        (rdata[g]),
      .o_sram_addr    (s_addr[g]),
      .o_sram_enable_x(en_x[g]),
      .o_sram_write_x (wr_x[g]),
      .o_sram_wdata   (s_wdata[g]),
      .i_sram_rdata   (s_rdata[g])
    );

    // Level-sensitive asynchronous SRAM
    always @(en_x[g] or wr_x[g] or s_addr[g] or s_wdata[g]) begin
      if (!en_x[g] && !wr_x[g]) mem[s_addr[g]] = s_wdata[g];
    end
    assign s_rdata[g] = (!en_x[g] && wr_x[g]) ? mem[s_addr[g]] : 'x;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_cyc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Completion monitor: every ack pops one expected access
  always @(negedge clk) begin : mon
    sb_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst_x && prev_en[i] && !en_x[i]) strobe_cnt[i]++;
      prev_en[i] = en_x[i];
      if (ack[i]) begin
        ack_cnt[i]++;
        if (sb_q.size() == 0) begin
          chk("spurious_ack", 32'(i), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_inst", 32'(i), 32'(e.inst));
          if (!e.we && e.chk) chk("sb_rdata", 32'(rdata[i]), 32'(e.data));
        end
      end
    end
  end

  // Drive a request once the instance is idle; leaves i_req high on return
  task automatic issue(input int i, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output bit ok);
    int  guard;
    int  key;
    sb_t e;
    guard = 0;
    ok    = 1'b0;
    @(negedge clk);
    while (busy[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy[i]) begin
      chk("issue_timeout", 32'(busy[i]), 32'd0);
      return;
    end
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    @(posedge clk);
    #1;
    chk("accept_busy", 32'(busy[i]), 32'd1);
    ok       = busy[i];
    last_acc = $time;
    if (ok) begin
      key    = i * 65536 + int'(a);
      e.inst = i;
      e.we   = w;
      e.addr = a;
      if (w) begin
        ref_mem[key] = d;
        e.data = d;
        e.chk  = 1'b0;
      end else begin
        e.chk  = ref_mem.exists(key);
        e.data = e.chk ? ref_mem[key] : '0;
      end
      sb_q.push_back(e);
    end
  endtask

  // Watch one access cycle by cycle after acceptance and check strobe shape and timing
  task automatic trace(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c;
    int n_en, n_wr, n_bad, n_busy, n_ack, ack_at, n_addr;
    c = eff_cyc(i);
    n_en = 0; n_wr = 0; n_bad = 0; n_busy = 0; n_ack = 0; ack_at = -1; n_addr = 0;
    for (int k = 0; k < c + 4; k++) begin
      @(negedge clk);
      if (k == 0) req[i] = 1'b0;
      if (!en_x[i]) n_en++;
      if (!wr_x[i]) n_wr++;
      if (!wr_x[i] && en_x[i]) n_bad++;
      if (busy[i]) begin
        n_busy++;
        if (s_addr[i] !== a || (w && s_wdata[i] !== d)) n_addr++;
      end
      if (ack[i]) begin
        n_ack++;
        if (ack_at < 0) ack_at = k;
      end
    end
    chk("en_low_clks",   32'(n_en),   32'(c));
    chk("wr_low_clks",   32'(n_wr),   w ? 32'(c) : 32'd0);
    chk("wr_without_en", 32'(n_bad),  32'd0);
    chk("busy_clks",     32'(n_busy), 32'(c + 2));
    chk("ack_clks",      32'(n_ack),  32'd1);
    chk("ack_latency",   32'(ack_at), 32'(c + 1));
    chk("addr_stable",   32'(n_addr), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit  ok;
    int  a0, s0, guard;
    time t_prev;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end

    #2 rst_x = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en_x",  32'(en_x[0]),    32'd1);
    chk("rst_wr_x",  32'(wr_x[0]),    32'd1);
    chk("rst_busy",  32'(busy[0]),    32'd0);
    chk("rst_ack",   32'(ack[0]),     32'd0);
    chk("rst_rdata", 32'(rdata[0]),   32'd0);
    chk("rst_addr",  32'(s_addr[0]),  32'd0);
    chk("rst_wdata", 32'(s_wdata[0]), 32'd0);
    rst_x = 1'b1;

    // Single write then read back at the same address
    issue(0, 1'b1, 16'h1234, 8'hA5, ok);
    trace(0, 1'b1, 16'h1234, 8'hA5);
    issue(0, 1'b0, 16'h1234, 8'h00, ok);
    trace(0, 1'b0, 16'h1234, 8'h00);
    chk("rdata_held", 32'(rdata[0]), 32'hA5);
    issue(0, 1'b1, 16'h4321, 8'h3C, ok);
    trace(0, 1'b1, 16'h4321, 8'h3C);
    chk("rdata_held_after_wr", 32'(rdata[0]), 32'hA5);

    // Back-to-back with i_req held high, including the top address
    t_prev = 0;
    for (int j = 0; j < 4; j++) begin
      issue(0, b2b_we[j], b2b_addr[j], b2b_data[j], ok);
      if (j > 0) chk("b2b_period", 32'(last_acc - t_prev), 32'd50);
      t_prev = last_acc;
    end
    @(negedge clk);
    req[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_rdata_last", 32'(rdata[0]), 32'h02);

    // Request pulsed while busy must be ignored
    a0 = ack_cnt[0];
    s0 = strobe_cnt[0];
    issue(0, 1'b1, 16'h0100, 8'h5A, ok);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0200; wdata[0] = 8'hEE;
    @(negedge clk);
    req[0] = 1'b0;
    guard = 0;
    while (busy[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ignore_busy_drop", 32'(busy[0]), 32'd0);
    repeat (8) @(negedge clk);
    chk("ignore_acks",    32'(ack_cnt[0] - a0),    32'd1);
    chk("ignore_strobes", 32'(strobe_cnt[0] - s0), 32'd1);
    issue(0, 1'b0, 16'h0100, 8'h00, ok);
    trace(0, 1'b0, 16'h0100, 8'h00);

    // Asynchronous reset in the middle of a write strobe
    issue(0, 1'b1, 16'h0300, 8'h77, ok);
    req[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_en_low", 32'(en_x[0]), 32'd0);
    rst_x = 1'b0;
    #1;
    chk("mid_rst_en_x",  32'(en_x[0]),  32'd1);
    chk("mid_rst_wr_x",  32'(wr_x[0]),  32'd1);
    chk("mid_rst_busy",  32'(busy[0]),  32'd0);
    chk("mid_rst_ack",   32'(ack[0]),   32'd0);
    chk("mid_rst_rdata", 32'(rdata[0]), 32'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    ref_mem.delete(16'h0300);
    @(negedge clk);
    rst_x = 1'b1;
    issue(0, 1'b0, 16'h0300, 8'h00, ok);
    trace(0, 1'b0, 16'h0300, 8'h00);

    // Degenerate cycle counts behave as a single strobe clock
    for (int i = 1; i < NI; i++) begin
      issue(i, 1'b1, 16'h0042, 8'(8'h3C + i), ok);
      trace(i, 1'b1, 16'h0042, 8'(8'h3C + i));
      issue(i, 1'b0, 16'h0042, 8'h00, ok);
      trace(i, 1'b0, 16'h0042, 8'h00);
      chk("short_rdata", 32'(rdata[i]), 32'(8'h3C + i));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
